// File: rtl/pll_reconfig_seq.sv
// Run-time reprogramming sequencer for a Cyclone V fractional PLL through the reconfig IP's Avalon-MM port.
// Optional dynamic phase-shift step is built when PLL_RECONFIG_DPS_EN is defined.
module pll_reconfig_seq #(
   parameter int unsigned NUM_CLK      = 2,
   parameter int unsigned LOCK_TIMEOUT = 65535,
   parameter int unsigned POLL_MODE    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [17:0]           cfg_m,
   input  logic [17:0]           cfg_n,
   input  logic [31:0]           cfg_k,
   input  logic [NUM_CLK*18-1:0] cfg_c,
   input  logic [NUM_CLK-1:0]    cfg_c_mask,
`ifdef PLL_RECONFIG_DPS_EN
   input  logic [15:0]           cfg_ps_steps,
   input  logic [4:0]            cfg_ps_sel,
   input  logic                  cfg_ps_up,
`endif
   output logic [5:0]            mgmt_address,
   output logic                  mgmt_write,
   output logic                  mgmt_read,
   output logic [31:0]           mgmt_writedata,
   input  logic [31:0]           mgmt_readdata,
   input  logic                  mgmt_waitrequest,
   input  logic                  pll_locked,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CW    = 18;
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 1);
   localparam int unsigned IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

   localparam logic [5:0] ADDR_MODE   = 6'h00;
   localparam logic [5:0] ADDR_STATUS = 6'h01;
   localparam logic [5:0] ADDR_START  = 6'h02;
   localparam logic [5:0] ADDR_N      = 6'h03;
   localparam logic [5:0] ADDR_M      = 6'h04;
   localparam logic [5:0] ADDR_C      = 6'h05;
   localparam logic [5:0] ADDR_DPS    = 6'h06;
   localparam logic [5:0] ADDR_K      = 6'h07;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLK - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(LOCK_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_HIT  = TMO_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_MODE,
      ST_WR_N,
      ST_WR_M,
      ST_WR_C,
      ST_WR_K,
      ST_WR_DPS,
      ST_START,
      ST_POLL,
      ST_WAIT_LOCK
   } state_t;

   state_t                 state_q, state_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;
   logic                   wr_q, wr_d;
   logic                   rd_q, rd_d;
   logic [5:0]             addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [TMO_W-1:0]       tmo_q, tmo_d;
   logic [CW-1:0]          m_q, m_d;
   logic [CW-1:0]          n_q, n_d;
   logic [31:0]            k_q, k_d;
   logic [NUM_CLK*CW-1:0]  c_q, c_d;
   logic [NUM_CLK-1:0]     mask_q, mask_d;
`ifdef PLL_RECONFIG_DPS_EN
   logic [15:0]            ps_steps_q, ps_steps_d;
   logic [4:0]             ps_sel_q, ps_sel_d;
   logic                   ps_up_q, ps_up_d;
`endif

   logic [IDX_W-1:0]       idx_nxt_c;
   logic                   timeout_c;

   // C counter write data: channel select in [22:18], counter word below it
   function automatic logic [31:0] c_data(input logic [NUM_CLK*CW-1:0] words,
                                          input logic [IDX_W-1:0] i);
      return {9'b0, 5'(i), words[int'(i)*CW +: CW]};
   endfunction

   assign idx_nxt_c = idx_q + IDX_W'(1);
   assign timeout_c = (tmo_q >= TMO_HIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         idx_q      <= '0;
         tmo_q      <= '0;
         m_q        <= '0;
         n_q        <= '0;
         k_q        <= '0;
         c_q        <= '0;
         mask_q     <= '0;
`ifdef PLL_RECONFIG_DPS_EN
         ps_steps_q <= '0;
         ps_sel_q   <= '0;
         ps_up_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         idx_q      <= idx_d;
         tmo_q      <= tmo_d;
         m_q        <= m_d;
         n_q        <= n_d;
         k_q        <= k_d;
         c_q        <= c_d;
         mask_q     <= mask_d;
`ifdef PLL_RECONFIG_DPS_EN
         ps_steps_q <= ps_steps_d;
         ps_sel_q   <= ps_sel_d;
         ps_up_q    <= ps_up_d;
`endif
      end
   end

   // Each write state has a strobe phase (wr_q=1) and an idle phase that launches the next access
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      wr_d       = wr_q;
      rd_d       = rd_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      idx_d      = idx_q;
      tmo_d      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
      m_d        = m_q;
      n_d        = n_q;
      k_d        = k_q;
      c_d        = c_q;
      mask_d     = mask_q;
`ifdef PLL_RECONFIG_DPS_EN
      ps_steps_d = ps_steps_q;
      ps_sel_d   = ps_sel_q;
      ps_up_d    = ps_up_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               m_d        = cfg_m;
               n_d        = cfg_n;
               k_d        = cfg_k;
               c_d        = cfg_c;
               mask_d     = cfg_c_mask;
`ifdef PLL_RECONFIG_DPS_EN
               ps_steps_d = cfg_ps_steps;
               ps_sel_d   = cfg_ps_sel;
               ps_up_d    = cfg_ps_up;
`endif
               err_d      = 1'b0;
               busy_d     = 1'b1;
               state_d    = ST_MODE;
               wr_d       = 1'b1;
               addr_d     = ADDR_MODE;
               wdata_d    = 32'(POLL_MODE);
            end
         end

         ST_MODE: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
            end else begin
               state_d = ST_WR_N;
               wr_d    = 1'b1;
               addr_d  = ADDR_N;
               wdata_d = {14'b0, n_q};
            end
         end

         ST_WR_N: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
            end else begin
               state_d = ST_WR_M;
               wr_d    = 1'b1;
               addr_d  = ADDR_M;
               wdata_d = {14'b0, m_q};
            end
         end

         ST_WR_M: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
            end else begin
               state_d = ST_WR_C;
               idx_d   = '0;
               wr_d    = mask_q[0];
               addr_d  = ADDR_C;
               wdata_d = c_data(c_q, '0);
            end
         end

         // A masked-out channel enters with the strobe low, so it costs exactly one idle cycle
         ST_WR_C: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
            end else if (idx_q == IDX_LAST) begin
               state_d = ST_WR_K;
               wr_d    = 1'b1;
               addr_d  = ADDR_K;
               wdata_d = k_q;
            end else begin
               idx_d   = idx_nxt_c;
               wr_d    = mask_q[idx_nxt_c];
               addr_d  = ADDR_C;
               wdata_d = c_data(c_q, idx_nxt_c);
            end
         end

         ST_WR_K: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
`ifdef PLL_RECONFIG_DPS_EN
            end else if (ps_steps_q != 16'd0) begin
               state_d = ST_WR_DPS;
               wr_d    = 1'b1;
               addr_d  = ADDR_DPS;
               wdata_d = {10'b0, ps_up_q, ps_sel_q, ps_steps_q};
`endif
            end else begin
               state_d = ST_START;
               wr_d    = 1'b1;
               addr_d  = ADDR_START;
               wdata_d = 32'd1;
               tmo_d   = '0;
            end
         end

`ifdef PLL_RECONFIG_DPS_EN
         ST_WR_DPS: begin
            if (wr_q) begin
               if (!mgmt_waitrequest) wr_d = 1'b0;
            end else begin
               state_d = ST_START;
               wr_d    = 1'b1;
               addr_d  = ADDR_START;
               wdata_d = 32'd1;
               tmo_d   = '0;
            end
         end
`endif

         // The first status read is a different strobe, so it follows START without a gap
         ST_START: begin
            if (!mgmt_waitrequest) begin
               state_d = ST_POLL;
               wr_d    = 1'b0;
               rd_d    = 1'b1;
               addr_d  = ADDR_STATUS;
            end
         end

         ST_POLL: begin
            if (rd_q && !mgmt_waitrequest && mgmt_readdata[0]) begin
               rd_d = 1'b0;
               if (pll_locked) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_WAIT_LOCK;
               end
            end else if (timeout_c) begin
               state_d = ST_IDLE;
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end else if (rd_q) begin
               if (!mgmt_waitrequest) rd_d = 1'b0;
            end else begin
               rd_d = 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            if (pll_locked) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else if (timeout_c) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               err_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            wr_d    = 1'b0;
            rd_d    = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign ready_d = (state_d == ST_IDLE);

   assign cfg_ready      = ready_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;
   assign mgmt_write     = wr_q;
   assign mgmt_read      = rd_q;
   assign mgmt_address   = addr_q;
   assign mgmt_writedata = wdata_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: Avalon accesses checked against a scoreboard of expected transfers.
module tb_pll_reconfig_seq;
   localparam int unsigned NUM_CLK      = 2;
   localparam int unsigned LOCK_TIMEOUT = 100;
   localparam int unsigned POLL_MODE    = 1;
   localparam int          BUDGET       = 400;

   typedef struct packed {
      logic        rd;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  hold;
   } acc_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  cfg_valid = 1'b0;
   logic                  cfg_ready;
   logic [17:0]           cfg_m = '0;
   logic [17:0]           cfg_n = '0;
   logic [31:0]           cfg_k = '0;
   logic [NUM_CLK*18-1:0] cfg_c = '0;
   logic [NUM_CLK-1:0]    cfg_c_mask = '0;
`ifdef PLL_RECONFIG_DPS_EN
   logic [15:0]           cfg_ps_steps = '0;
   logic [4:0]            cfg_ps_sel = '0;
   logic                  cfg_ps_up = 1'b0;
`endif
   logic [5:0]            mgmt_address;
   logic                  mgmt_write;
   logic                  mgmt_read;
   logic [31:0]           mgmt_writedata;
   logic [31:0]           mgmt_readdata;
   logic                  mgmt_waitrequest = 1'b0;
   logic                  pll_locked = 1'b1;
   logic                  busy;
   logic                  done;
   logic                  err;

   logic                  stat_done = 1'b1;
   int                    tests_run = 0;
   int                    tests_failed = 0;
   acc_t                  sb[$];
   logic [5:0]            stall_addr = 6'h3f;
   int                    stall_left = 0;
   bit                    any_reads = 1'b0;
   int                    done_cnt = 0;

   int                    held = 0;
   logic [5:0]            first_addr;
   logic [31:0]           first_data;
   bit                    b2b = 1'b0;
   bit                    prev_wr = 1'b0;
   bit                    prev_rd = 1'b0;

   assign mgmt_readdata = {31'b0, stat_done};

   always #5 clk = ~clk;

   pll_reconfig_seq #(
      .NUM_CLK(NUM_CLK), .LOCK_TIMEOUT(LOCK_TIMEOUT), .POLL_MODE(POLL_MODE)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_c(cfg_c), .cfg_c_mask(cfg_c_mask),
`ifdef PLL_RECONFIG_DPS_EN
      .cfg_ps_steps(cfg_ps_steps), .cfg_ps_sel(cfg_ps_sel), .cfg_ps_up(cfg_ps_up),
`endif
      .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
      .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
      .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked),
      .busy(busy), .done(done), .err(err)
   );

   // Slave model and scoreboard: waitrequest is decided first, then any completing access is popped
   always @(negedge clk) begin
      acc_t e;
      if (mgmt_write && mgmt_address == stall_addr && stall_left > 0) begin
         mgmt_waitrequest = 1'b1;
         stall_left--;
      end else begin
         mgmt_waitrequest = 1'b0;
      end
      if (done) done_cnt++;
      if (mgmt_write || mgmt_read) begin
         held++;
         if (held == 1) begin
            first_addr = mgmt_address;
            first_data = mgmt_writedata;
            b2b = (mgmt_write && prev_wr) || (mgmt_read && prev_rd);
         end
         if (!mgmt_waitrequest) begin
            tests_run++;
            if (mgmt_read && any_reads) begin
               if (mgmt_address !== 6'h01 || b2b || held != 1 || mgmt_write) begin
                  tests_failed++;
                  $display("FAIL poll_read: addr %h held %0d b2b %0d, want addr 01 held 1 b2b 0",
                           mgmt_address, held, b2b);
               end
            end else if (sb.size() == 0) begin
               tests_failed++;
               $display("FAIL unexpected_access: wr %0d rd %0d addr %h data %h, want none",
                        mgmt_write, mgmt_read, mgmt_address, mgmt_writedata);
            end else begin
               e = sb.pop_front();
               if (mgmt_read !== e.rd || mgmt_write === e.rd || mgmt_address !== e.addr
                   || (!e.rd && mgmt_writedata !== e.data) || held != int'(e.hold)
                   || first_addr !== mgmt_address || (!e.rd && first_data !== mgmt_writedata)
                   || b2b) begin
                  tests_failed++;
                  $display("FAIL access: rd %0d addr %h data %h held %0d b2b %0d, want rd %0d addr %h data %h held %0d b2b 0",
                           mgmt_read, mgmt_address, mgmt_writedata, held, b2b,
                           e.rd, e.addr, e.data, e.hold);
               end
            end
            held = 0;
         end
      end
      prev_wr = mgmt_write && !mgmt_waitrequest;
      prev_rd = mgmt_read && !mgmt_waitrequest;
   end

   task automatic push_acc(input logic rd, input logic [5:0] addr, input logic [31:0] data);
      acc_t e;
      e.rd   = rd;
      e.addr = addr;
      e.data = data;
      e.hold = (!rd && addr == stall_addr && stall_left > 0) ? 4'(stall_left + 1) : 4'd1;
      sb.push_back(e);
   endtask

   task automatic push_seq(input logic [NUM_CLK-1:0] mask, input logic [17:0] m, input logic [17:0] n,
                           input logic [31:0] k, input logic [NUM_CLK*18-1:0] c, input bit with_read);
      push_acc(1'b0, 6'h00, 32'(POLL_MODE));
      push_acc(1'b0, 6'h03, {14'b0, n});
      push_acc(1'b0, 6'h04, {14'b0, m});
      for (int i = 0; i < int'(NUM_CLK); i++)
         if (mask[i]) push_acc(1'b0, 6'h05, {9'b0, 5'(i), c[i*18 +: 18]});
      push_acc(1'b0, 6'h07, k);
`ifdef PLL_RECONFIG_DPS_EN
      if (cfg_ps_steps != 16'd0) push_acc(1'b0, 6'h06, {10'b0, cfg_ps_up, cfg_ps_sel, cfg_ps_steps});
`endif
      push_acc(1'b0, 6'h02, 32'd1);
      if (with_read) push_acc(1'b1, 6'h01, 32'd0);
   endtask

   task automatic send(input logic [NUM_CLK-1:0] mask, input logic [17:0] m, input logic [17:0] n,
                       input logic [31:0] k, input logic [NUM_CLK*18-1:0] c);
      @(negedge clk);
      cfg_m = m; cfg_n = n; cfg_k = k; cfg_c = c; cfg_c_mask = mask;
      cfg_valid = 1'b1;
      @(posedge clk);
      #1 cfg_valid = 1'b0;
   endtask

   // Cycles from the accepting edge to the first sample with done high (-1 if never)
   task automatic wait_done(output int lat, output logic busy0);
      lat = -1;
      busy0 = 1'b0;
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (k == 0) busy0 = busy;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      tests_run++;
      if (cfg_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_status: ready %b busy %b done %b err %b, want 1 0 0 0", cfg_ready, busy, done, err);
      end
      tests_run++;
      if (mgmt_write !== 1'b0 || mgmt_read !== 1'b0 || mgmt_address !== 6'h00 || mgmt_writedata !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_bus: wr %b rd %b addr %h data %h, want 0 0 00 00000000",
                  mgmt_write, mgmt_read, mgmt_address, mgmt_writedata);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int lat;
      logic b0;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h1_3311, 18'h2_0a05};
      stat_done = 1'b1;
      pll_locked = 1'b1;
      push_seq(2'b11, 18'h0_0403, 18'h1_0101, 32'h8000_1234, c, 1'b1);
      send(2'b11, 18'h0_0403, 18'h1_0101, 32'h8000_1234, c);
      wait_done(lat, b0);
      tests_run++;
      if (b0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_busy: busy after accept %b, want 1", b0);
      end
      tests_run++;
      if (lat != 14) begin
         tests_failed++;
         $display("FAIL basic_latency: %0d cycles, want 14", lat);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL basic_after: done %b busy %b ready %b, want 0 0 1", done, busy, cfg_ready);
      end
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL basic_drain: %0d accesses missing, want 0", sb.size());
      end
   endtask

   task automatic test_waitrequest();
      int lat;
      logic b0;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h0_0707, 18'h0_0102};
      stall_addr = 6'h04;
      stall_left = 3;
      push_seq(2'b11, 18'h2_1020, 18'h0_0001, 32'h0000_0000, c, 1'b1);
      send(2'b11, 18'h2_1020, 18'h0_0001, 32'h0000_0000, c);
      wait_done(lat, b0);
      tests_run++;
      if (lat != 17) begin
         tests_failed++;
         $display("FAIL waitreq_latency: %0d cycles, want 17", lat);
      end
      tests_run++;
      if (stall_left != 0 || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL waitreq_drain: stall_left %0d queue %0d, want 0 0", stall_left, sb.size());
      end
      stall_addr = 6'h3f;
      @(negedge clk);
   endtask

   task automatic test_mask_busy();
      int lat;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h3_ffff, 18'h1_5555};
      lat = -1;
      push_seq(2'b10, 18'h0_0a0b, 18'h0_0c0d, 32'hdead_beef, c, 1'b1);
      send(2'b10, 18'h0_0a0b, 18'h0_0c0d, 32'hdead_beef, c);
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (k == 2) begin
            cfg_valid = 1'b1;
            cfg_m = 18'h3_0000;
            cfg_c_mask = 2'b11;
         end
         if (k == 8) cfg_valid = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
      tests_run++;
      if (lat != 13) begin
         tests_failed++;
         $display("FAIL mask_latency: %0d cycles, want 13", lat);
      end
      repeat (6) @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || sb.size() != 0 || done_cnt == 0) begin
         tests_failed++;
         $display("FAIL mask_ignore: busy %b queue %0d, want 0 0", busy, sb.size());
      end
   endtask

   task automatic test_wait_lock();
      int lat;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h0_0303, 18'h0_0202};
      lat = -1;
      pll_locked = 1'b0;
      push_seq(2'b11, 18'h0_0505, 18'h0_0101, 32'h1, c, 1'b1);
      send(2'b11, 18'h0_0505, 18'h0_0101, 32'h1, c);
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
         if (k == 18) pll_locked = 1'b1;
      end
      tests_run++;
      if (lat != 19) begin
         tests_failed++;
         $display("FAIL lock_latency: %0d cycles, want 19", lat);
      end
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int k_start, k_err, dc0, lat;
      logic b0;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h0_1111, 18'h0_2222};
      k_start = -1;
      k_err = -1;
      stat_done = 1'b0;
      any_reads = 1'b1;
      dc0 = done_cnt;
      push_seq(2'b11, 18'h0_0606, 18'h0_0101, 32'h55, c, 1'b0);
      send(2'b11, 18'h0_0606, 18'h0_0101, 32'h55, c);
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (k_start < 0 && mgmt_write && mgmt_address == 6'h02) k_start = k;
         if (err) begin
            k_err = k;
            break;
         end
      end
      tests_run++;
      if (k_start < 0 || k_err - k_start != 100) begin
         tests_failed++;
         $display("FAIL timeout_cycle: err %0d cycles after START (start seen %0d), want 100",
                  k_err - k_start, k_start);
      end
      tests_run++;
      if (done_cnt != dc0 || busy !== 1'b0 || cfg_ready !== 1'b1 || mgmt_read !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_state: done pulses %0d busy %b ready %b rd %b, want 0 0 1 0",
                  done_cnt - dc0, busy, cfg_ready, mgmt_read);
      end
      any_reads = 1'b0;
      stat_done = 1'b1;
      repeat (3) @(negedge clk);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++;
         $display("FAIL err_sticky: err %b, want 1", err);
      end
      push_seq(2'b01, 18'h0_0707, 18'h0_0101, 32'h66, c, 1'b1);
      send(2'b01, 18'h0_0707, 18'h0_0101, 32'h66, c);
      wait_done(lat, b0);
      tests_run++;
      if (lat != 13 || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL err_clear_run: latency %0d queue %0d, want 13 0", lat, sb.size());
      end
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++;
         $display("FAIL err_clear: err %b, want 0", err);
      end
   endtask

   task automatic test_reset_mid();
      bit found;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h0_0909, 18'h0_0808};
      found = 1'b0;
      push_seq(2'b11, 18'h0_0101, 18'h0_0101, 32'h7, c, 1'b1);
      send(2'b11, 18'h0_0101, 18'h0_0101, 32'h7, c);
      for (int k = 0; k < BUDGET; k++) begin
         @(negedge clk);
         if (mgmt_write && mgmt_address == 6'h05) begin
            found = 1'b1;
            break;
         end
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (!found || mgmt_write !== 1'b0 || cfg_ready !== 1'b1 || busy !== 1'b0 || mgmt_read !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: found %0d wr %b ready %b busy %b rd %b, want 1 0 1 0 0",
                  found, mgmt_write, cfg_ready, busy, mgmt_read);
      end
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

`ifdef PLL_RECONFIG_DPS_EN
   task automatic test_dps();
      int lat;
      logic b0;
      logic [NUM_CLK*18-1:0] c;
      c = {18'h0_0404, 18'h0_0303};
      cfg_ps_steps = 16'd5;
      cfg_ps_sel = 5'd1;
      cfg_ps_up = 1'b1;
      push_seq(2'b11, 18'h0_0202, 18'h0_0101, 32'h9, c, 1'b1);
      send(2'b11, 18'h0_0202, 18'h0_0101, 32'h9, c);
      wait_done(lat, b0);
      tests_run++;
      if (lat != 16 || sb.size() != 0) begin
         tests_failed++;
         $display("FAIL dps_run: latency %0d queue %0d, want 16 0", lat, sb.size());
      end
      cfg_ps_steps = 16'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_waitrequest();
      test_mask_busy();
      test_wait_lock();
      test_timeout();
      test_reset_mid();
`ifdef PLL_RECONFIG_DPS_EN
      test_dps();
`endif
      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
